traffic_phase_ctrl: RTL and testbench
=====================================

# traffic_phase_ctrl

Parametrised, sensor-actuated successor to the fixed-schedule highway/farm controller. It drives any number of highway and farm signal heads from one phase state machine. Highway green is held by default and yields to the farm road only on a latched vehicle request. It adds a tick prescaler, per-phase durations set by parameters, a go/pause input, and a flashing maintenance mode. It sits directly under the intersection top level and drives the lamp decoders.

## Interface
- N_HW, 2: number of highway signal heads
- N_FARM, 2: number of farm signal heads
- TICK_DIV, 50_000_000: clk cycles per tick (≥1)
- T_ALLRED, 1: all-red clearance, ticks (≥1)
- T_YEL, 3: yellow, ticks (≥1)
- T_HW_MIN, 30: minimum highway green, ticks (≥1)
- T_FARM, 15: farm green, ticks (≥1)
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- go  in  1  1 = run; 0 = freeze prescaler, timer and state
- farm_req  in  1  farm vehicle sensor, level, sampled every clk
- flash_en  in  1  request flashing maintenance mode
- hw_sig  out  2*N_HW  highway heads, 2 bits each, head i at [2i+1:2i]
- farm_sig  out  2*N_FARM  farm heads, 2 bits each
- phase  out  3  current state code
- phase_start  out  1  one-cycle pulse on every state entry

## Operation
- Signal encoding: 00 GREEN, 01 YELLOW, 10 RED, 11 OFF. All heads of one road carry identical values.
- States and codes:
  - ALLRED_A 0: all RED
  - HW_GRN 1: hw GREEN, farm RED
  - HW_YEL 2: hw YELLOW, farm RED
  - ALLRED_B 3: all RED
  - FARM_GRN 4: hw RED, farm GREEN
  - FARM_YEL 5: hw RED, farm YELLOW
  - FLASH 6
- Cycle order: ALLRED_A → HW_GRN → HW_YEL → ALLRED_B → FARM_GRN → FARM_YEL → ALLRED_A.
- Durations: ALLRED T_ALLRED, YEL T_YEL, FARM_GRN T_FARM.
- HW_GRN lasts at least T_HW_MIN, then exits on the first tick boundary where req_lat=1. Without a request it holds indefinitely.
- req_lat:
  - set by farm_req=1 in any cycle outside FARM_GRN
  - cleared on entry to FARM_GRN; farm_req on that same cycle is ignored
  - cleared by rst
- flash_en=1:
  - In HW_GRN or FARM_GRN, the green is truncated at the next tick and the machine enters that road's YEL for the full T_YEL, then FLASH.
  - In any other state, the current phase completes, then the machine goes to FLASH.
- FLASH:
  - Lit half: hw YELLOW, farm RED.
  - Dark half: all OFF.
  - Starts lit and toggles every tick.
  - When flash_en=0 at a tick boundary, the machine goes to ALLRED_A.
- go=0: everything holds, including outputs and the flash toggle. farm_req is still latched.
- Phase timer width: $clog2(max T + 1). Saturating increment; it never wraps.

## Timing
- Reset (edge with rst=1): state ALLRED_A, all heads RED, phase=0, phase_start=0, prescaler=0, timer=0, req_lat=0. rst has priority over go and flash_en.
- tick: asserted on the cycle where prescaler=TICK_DIV-1 and go=1.
- Prescaler and timer restart at 0 on every state change, so each phase is exactly T×TICK_DIV clk cycles when go is held high.
- A transition happens on the clk edge where tick=1 and timer=T-1. State, outputs and phase_start all update on that edge, so outputs are registered with zero extra latency.
- go low for k cycles lengthens the current phase by exactly k cycles.
- farm_req seen by the edge before the last HW_GRN tick edge is honoured on that tick.

## Structure
- Package traffic_pkg holds:
  - sig_t enum {GREEN, YELLOW, RED, OFF}
  - state_t enum with the codes above
  - function replicating a sig_t across N heads
- Sub-module tick_prescaler:
  - inputs: clk, rst, go, clr
  - output: tick
  - parameter: TICK_DIV
- The FSM, timer and request latch live in the top module.

## Test plan
All scenarios use TICK_DIV=2, T_ALLRED=1, T_YEL=2, T_HW_MIN=4, T_FARM=3, N_HW=2, N_FARM=1.
- Reset, then go=1: all heads RED (hw_sig=4'b1010, farm_sig=2'b10) for 2 clks, then HW_GRN with hw_sig=4'b0000 and a phase_start pulse.
- farm_req never asserted: HW_GRN holds for 200 clks; no other state is entered.
- farm_req pulsed 1 clk at clk 1 of HW_GRN:
  - HW_GRN 8 clks
  - HW_YEL 4
  - ALLRED_B 2
  - FARM_GRN 6
  - FARM_YEL 4
  - ALLRED_A 2
  - back to HW_GRN, with req_lat=0
- go=0 for 10 clks mid FARM_GRN: outputs frozen; FARM_GRN totals 16 clks.
- flash_en=1 at clk 2 of HW_GRN with req_lat=0:
  - HW_YEL at the next tick, lasting 4 clks
  - FLASH: hw YELLOW/farm RED for 2 clks, then all OFF for 2 clks, repeating
  - flash_en=0 → ALLRED_A at the next tick
- rst at clk 1 of FARM_YEL: next edge shows all RED, phase=0, req_lat=0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types for the traffic phase controller: lamp encodings, phase codes
// and a helper that fans one lamp value out to a bank of identical heads.
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10,
        OFF    = 2'b11
    } sig_t;

    typedef enum logic [2:0] {
        ALLRED_A = 3'd0,
        HW_GRN   = 3'd1,
        HW_YEL   = 3'd2,
        ALLRED_B = 3'd3,
        FARM_GRN = 3'd4,
        FARM_YEL = 3'd5,
        FLASH    = 3'd6
    } state_t;

    // Widest head bank the replication helper can serve.
    localparam int unsigned MAX_HEADS = 32;

    // Callers truncate the result to 2*N bits for an N-head bank.
    function automatic logic [2*MAX_HEADS-1:0] rep_sig(input sig_t s);
        return {MAX_HEADS{s}};
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV running cycles;
// go=0 freezes the count and clr restarts it from zero.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = go && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (go) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Sensor-actuated highway/farm phase controller: highway green by default,
// yields to the farm road on a latched request, with a flashing maintenance mode.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned N_HW     = 2,
    parameter int unsigned N_FARM   = 2,
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned T_ALLRED = 1,
    parameter int unsigned T_YEL    = 3,
    parameter int unsigned T_HW_MIN = 30,
    parameter int unsigned T_FARM   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic                  farm_req,
    input  logic                  flash_en,
    output logic [2*N_HW-1:0]     hw_sig,
    output logic [2*N_FARM-1:0]   farm_sig,
    output logic [2:0]            phase,
    output logic                  phase_start
);

    localparam int unsigned T_M1  = (T_ALLRED > T_YEL) ? T_ALLRED : T_YEL;
    localparam int unsigned T_M2  = (T_HW_MIN > T_FARM) ? T_HW_MIN : T_FARM;
    localparam int unsigned T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
    localparam int unsigned TW    = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] T_SAT    = TW'(T_MAX);
    localparam logic [TW-1:0] AR_END   = TW'(T_ALLRED - 1);
    localparam logic [TW-1:0] YEL_END  = TW'(T_YEL - 1);
    localparam logic [TW-1:0] HW_END   = TW'(T_HW_MIN - 1);
    localparam logic [TW-1:0] FARM_END = TW'(T_FARM - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          req_q,   req_d;
    logic          lit_q,   lit_d;
    logic          start_q, start_d;
    sig_t          hw_q,    hw_d;
    sig_t          farm_q,  farm_d;
    logic          tick;
    logic          adv;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .go   (go),
        .clr  (adv),
        .tick (tick)
    );

    // Next state, timer, request latch, flash phase and lamp decode.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        req_d   = req_q;
        lit_d   = lit_q;
        hw_d    = RED;
        farm_d  = RED;
        adv     = 1'b0;
        start_d = 1'b0;

        if (tick) begin
            case (state_q)
                ALLRED_A: begin
                    if (timer_q == AR_END) begin
                        if (flash_en) state_d = FLASH;
                        else          state_d = HW_GRN;
                    end
                end
                HW_GRN: begin
                    if (flash_en || (req_q && (timer_q >= HW_END))) begin
                        state_d = HW_YEL;
                    end
                end
                HW_YEL: begin
                    if (timer_q == YEL_END) begin
                        if (flash_en) state_d = FLASH;
                        else          state_d = ALLRED_B;
                    end
                end
                ALLRED_B: begin
                    if (timer_q == AR_END) begin
                        if (flash_en) state_d = FLASH;
                        else          state_d = FARM_GRN;
                    end
                end
                FARM_GRN: begin
                    if (flash_en || (timer_q == FARM_END)) begin
                        state_d = FARM_YEL;
                    end
                end
                FARM_YEL: begin
                    if (timer_q == YEL_END) begin
                        if (flash_en) state_d = FLASH;
                        else          state_d = ALLRED_A;
                    end
                end
                FLASH: begin
                    if (!flash_en) state_d = ALLRED_A;
                end
                default: state_d = ALLRED_A;
            endcase
        end

        adv     = (state_d != state_q);
        start_d = adv;

        // Timer restarts on every phase change and saturates instead of wrapping.
        if (adv) begin
            timer_d = '0;
        end else if (tick && (timer_q != T_SAT)) begin
            timer_d = timer_q + TW'(1);
        end

        if (adv) begin
            lit_d = 1'b1;
        end else if (tick && (state_q == FLASH)) begin
            lit_d = ~lit_q;
        end

        // A request arriving on the FARM_GRN entry cycle is deliberately dropped.
        if (adv && (state_d == FARM_GRN)) begin
            req_d = 1'b0;
        end else if (farm_req && (state_q != FARM_GRN)) begin
            req_d = 1'b1;
        end

        case (state_d)
            HW_GRN:   hw_d   = GREEN;
            HW_YEL:   hw_d   = YELLOW;
            FARM_GRN: farm_d = GREEN;
            FARM_YEL: farm_d = YELLOW;
            FLASH: begin
                if (lit_d) begin
                    hw_d = YELLOW;
                end else begin
                    hw_d   = OFF;
                    farm_d = OFF;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ALLRED_A;
            timer_q <= '0;
            req_q   <= 1'b0;
            lit_q   <= 1'b1;
            start_q <= 1'b0;
            hw_q    <= RED;
            farm_q  <= RED;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            req_q   <= req_d;
            lit_q   <= lit_d;
            start_q <= start_d;
            hw_q    <= hw_d;
            farm_q  <= farm_d;
        end
    end

    assign hw_sig      = (2*N_HW)'(rep_sig(hw_q));
    assign farm_sig    = (2*N_FARM)'(rep_sig(farm_q));
    assign phase       = 3'(state_q);
    assign phase_start = start_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: walks the full phase cycle, go freeze,
// request latching, mid-phase reset and the flashing maintenance mode.
module tb_traffic_phase_ctrl;

    localparam int HW_G = 'b0000;
    localparam int HW_Y = 'b0101;
    localparam int HW_R = 'b1010;
    localparam int HW_O = 'b1111;
    localparam int F_G  = 'b00;
    localparam int F_Y  = 'b01;
    localparam int F_R  = 'b10;
    localparam int F_O  = 'b11;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       go       = 1'b0;
    logic       farm_req = 1'b0;
    logic       flash_en = 1'b0;
    logic [3:0] hw_sig;
    logic [1:0] farm_sig;
    logic [2:0] phase;
    logic       phase_start;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    traffic_phase_ctrl #(
        .N_HW     (2),
        .N_FARM   (1),
        .TICK_DIV (2),
        .T_ALLRED (1),
        .T_YEL    (2),
        .T_HW_MIN (4),
        .T_FARM   (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .farm_req    (farm_req),
        .flash_en    (flash_en),
        .hw_sig      (hw_sig),
        .farm_sig    (farm_sig),
        .phase       (phase),
        .phase_start (phase_start)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-cycle stimulus keyed on how many cycles the current phase has been visible.
    task automatic drive(input int len, input int req_at, input int gl_at, input int gl_n,
                         input int fl_at);
        farm_req = (len == req_at);
        go       = !((gl_n > 0) && (len >= gl_at) && (len < gl_at + gl_n));
        if (len == fl_at) flash_en = 1'b1;
    endtask

    // Called on the first negedge of a phase; returns on the first negedge of the next.
    task automatic measure(input string tag, input int ph, input int ehw, input int efarm,
                           input int estart, input int elen, input int req_at,
                           input int gl_at, input int gl_n, input int fl_at);
        int len;
        int bad;
        bit done;
        check({tag, "_phase"}, 32'(phase), ph);
        check({tag, "_start"}, 32'(phase_start), estart);
        check({tag, "_hw"}, 32'(hw_sig), ehw);
        check({tag, "_farm"}, 32'(farm_sig), efarm);
        len  = 1;
        bad  = 0;
        done = 1'b0;
        drive(len, req_at, gl_at, gl_n, fl_at);
        while (!done) begin
            @(negedge clk);
            if ((32'(phase) != ph) || (len > elen + 50)) begin
                done = 1'b1;
            end else begin
                len++;
                if ((32'(hw_sig) != ehw) || (32'(farm_sig) != efarm) || phase_start) bad++;
                drive(len, req_at, gl_at, gl_n, fl_at);
            end
        end
        farm_req = 1'b0;
        go       = 1'b1;
        check({tag, "_len"}, len, elen);
        check({tag, "_steady"}, bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        int cnt;

        repeat (3) @(negedge clk);
        check("rst_hw", 32'(hw_sig), HW_R);
        check("rst_farm", 32'(farm_sig), F_R);
        check("rst_phase", 32'(phase), 0);
        check("rst_start", 32'(phase_start), 0);

        // Full cycle: request pulse early in HW_GRN, go freeze plus ignored request in FARM_GRN.
        rst = 1'b0;
        go  = 1'b1;
        measure("ara0", 0, HW_R, F_R, 0, 2,  0, 0, 0,  0);
        measure("hwg1", 1, HW_G, F_R, 1, 8,  1, 0, 0,  0);
        measure("hwy1", 2, HW_Y, F_R, 1, 4,  0, 0, 0,  0);
        measure("arb1", 3, HW_R, F_R, 1, 2,  0, 0, 0,  0);
        measure("fg1",  4, HW_R, F_G, 1, 16, 4, 3, 10, 0);
        measure("fy1",  5, HW_R, F_Y, 1, 4,  0, 0, 0,  0);
        measure("ara1", 0, HW_R, F_R, 1, 2,  0, 0, 0,  0);

        // Back in HW_GRN with no pending request: green must hold.
        check("hold_phase", 32'(phase), 1);
        check("hold_start", 32'(phase_start), 1);
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if ((phase != 3'd1) || (hw_sig != 4'b0000) || (farm_sig != 2'b10)) bad++;
        end
        check("hold200", bad, 0);

        // Request now, then reset on the first cycle of FARM_YEL with a request pending.
        farm_req = 1'b1;
        @(negedge clk);
        farm_req = 1'b0;
        cnt = 0;
        while ((phase != 3'd5) && (cnt < 100)) begin
            @(negedge clk);
            cnt++;
        end
        check("reach_fy", 32'(phase), 5);
        check("reach_fy_start", 32'(phase_start), 1);
        rst      = 1'b1;
        farm_req = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        farm_req = 1'b0;
        check("rst2_hw", 32'(hw_sig), HW_R);
        check("rst2_farm", 32'(farm_sig), F_R);
        check("rst2_phase", 32'(phase), 0);
        check("rst2_start", 32'(phase_start), 0);

        // HW_GRN running 32 clks proves the request was cleared; flash then truncates it.
        measure("ara2", 0, HW_R, F_R, 0, 2,  0, 0, 0, 0);
        measure("hwg2", 1, HW_G, F_R, 1, 32, 0, 0, 0, 31);
        measure("hwy2", 2, HW_Y, F_R, 1, 4,  0, 0, 0, 0);

        check("fl_phase", 32'(phase), 6);
        check("fl_start", 32'(phase_start), 1);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) check("fl_lit_hw", 32'(hw_sig), HW_Y);
            if (k == 2) check("fl_dark_hw", 32'(hw_sig), HW_O);
            if (((k / 2) % 2) == 0) begin
                if ((32'(hw_sig) != HW_Y) || (32'(farm_sig) != F_R)) bad++;
            end else begin
                if ((32'(hw_sig) != HW_O) || (32'(farm_sig) != F_O)) bad++;
            end
            if (phase != 3'd6) bad++;
            if (k == 7) flash_en = 1'b0;
            @(negedge clk);
        end
        check("fl_pattern", bad, 0);

        measure("ara3", 0, HW_R, F_R, 1, 2, 0, 0, 0, 0);
        check("hwg3_phase", 32'(phase), 1);
        check("hwg3_hw", 32'(hw_sig), HW_G);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
